instr_fetch_mem: RTL and testbench

Parametrised instruction memory with an internal fetch counter and a registered output using a valid/ready handshake.
- Supports redirect (jump/branch target load), run/stop control and a program-load write port.
- Sits between the program loader and the decode stage of the core.
- Replaces the fixed-size, always-advancing instruction memory.

---
 rtl/instr_fetch_mem.sv | 150 +++++++++++++++
 tb/tb_instr_fetch_mem.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_mem.sv
// Instruction memory with internal fetch counter and registered valid/ready output.
// Optional per-word even parity with error flag: define INSTR_MEM_PARITY_EN.
module instr_fetch_mem #(
    parameter int    XLEN      = 32,
    parameter int    DEPTH     = 64,
    parameter int    ADDR_W    = $clog2(DEPTH),
    parameter int    RESET_PC  = 0,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    input  logic              instr_ready,
    output logic              instr_valid,
    output logic [XLEN-1:0]   instr,
    output logic [ADDR_W-1:0] instr_addr,
    output logic              instr_err,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [XLEN-1:0]   wr_data
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    // Reduce an index that may exceed DEPTH-1 (non-power-of-2 DEPTH).
    function automatic logic [ADDR_W-1:0] fold(input logic [ADDR_W-1:0] a);
        if ({1'b0, a} >= DEPTH_W) return a - ADDR_W'(DEPTH);
        return a;
    endfunction

    // Increment modulo DEPTH.
    function automatic logic [ADDR_W-1:0] inc(input logic [ADDR_W-1:0] a);
        if (a == LAST) return '0;
        return a + ADDR_W'(1);
    endfunction

    logic [XLEN-1:0]   mem [DEPTH];
    state_t            state, state_d;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] rd_addr;
    logic              slot_free;
    logic              do_fetch;
    logic              do_drop;
    logic              rd_err;

`ifdef INSTR_MEM_PARITY_EN
    logic par [DEPTH];
`endif

    // Power-up contents: a small repeating test program.
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            if (XLEN != 32)      mem[i] = '0;
            else if (i % 3 == 0) mem[i] = XLEN'(32'h00A00093);
            else if (i % 3 == 1) mem[i] = XLEN'(32'h00108133);
            else                 mem[i] = XLEN'(32'h00208203);
        end
`ifdef INSTR_MEM_PARITY_EN
        for (int i = 0; i < DEPTH; i++) par[i] = ^mem[i];
`endif
    end

    assign slot_free = !instr_valid || instr_ready;
    assign rd_addr   = redirect_valid ? fold(redirect_addr) : pc;

`ifdef INSTR_MEM_PARITY_EN
    assign rd_err = par[rd_addr] != (^mem[rd_addr]);
`else
    assign rd_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_d;
    end

    // Next-state: redirect overrides, otherwise fetch_en steers RUN/DRAIN/IDLE.
    always_comb begin
        state_d = state;
        if (redirect_valid) begin
            state_d = fetch_en ? RUN : DRAIN;
        end else begin
            unique case (state)
                IDLE:  state_d = fetch_en ? RUN : IDLE;
                RUN:   state_d = fetch_en ? RUN : DRAIN;
                DRAIN: begin
                    if (fetch_en)       state_d = RUN;
                    else if (slot_free) state_d = IDLE;
                end
            endcase
        end
    end

    // Output decode: when to load a new word and when to retire the held one.
    always_comb begin
        do_fetch = 1'b0;
        do_drop  = 1'b0;
        if (redirect_valid) begin
            do_fetch = 1'b1;
        end else begin
            unique case (state)
                IDLE: do_fetch = fetch_en;
                RUN, DRAIN: begin
                    do_fetch = fetch_en && slot_free;
                    do_drop  = !fetch_en && instr_ready;
                end
            endcase
        end
    end

    // Fetch counter advances past every word loaded into the output slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)      pc <= ADDR_W'(RESET_PC);
        else if (do_fetch) pc <= inc(rd_addr);
    end

    // Output slot: loaded on fetch, cleared on acceptance, held on stall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_addr  <= '0;
            instr_err   <= 1'b0;
        end else if (do_fetch) begin
            instr_valid <= 1'b1;
            instr       <= mem[rd_addr];
            instr_addr  <= rd_addr;
            instr_err   <= rd_err;
        end else if (do_drop) begin
            instr_valid <= 1'b0;
        end
    end

    // Program-load port; the read above sees the pre-write word.
    always_ff @(posedge clk) begin
        if (wr_en && ({1'b0, wr_addr} < DEPTH_W)) begin
            mem[wr_addr] <= wr_data;
`ifdef INSTR_MEM_PARITY_EN
            par[wr_addr] <= ^wr_data;
`endif
        end
    end

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Bench for instr_fetch_mem: directed steps plus random traffic against
// a cycle-level reference model of the fetch stream.
module tb_instr_fetch_mem;

    localparam int DEPTH = 64;

`ifdef INSTR_MEM_PARITY_EN
    localparam bit EXP_ERR3 = 1'b1;
`else
    localparam bit EXP_ERR3 = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        fetch_en;
    logic        redirect_valid;
    logic [5:0]  redirect_addr;
    logic        instr_ready;
    logic        instr_valid;
    logic [31:0] instr;
    logic [5:0]  instr_addr;
    logic        instr_err;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;

    int checks = 0;
    int fails  = 0;

    logic [31:0] m_mem [DEPTH];
    bit          m_bad [DEPTH];
    int          m_pc;
    bit          m_v;
    logic [31:0] m_instr;
    int          m_addr;
    bit          m_err;

    always #5 clk = ~clk;

    instr_fetch_mem dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .instr_ready    (instr_ready),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_addr     (instr_addr),
        .instr_err      (instr_err),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data)
    );

    function automatic logic [31:0] dflt(input int i);
        case (i % 3)
            0:       return 32'h00A00093;
            1:       return 32'h00108133;
            default: return 32'h00208203;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = 0;
        m_v     = 1'b0;
        m_instr = '0;
        m_addr  = 0;
        m_err   = 1'b0;
    endtask

    task automatic apply(input bit fe, input bit rv, input int ra,
                         input bit rdy, input bit we, input int wa,
                         input logic [31:0] wd);
        int a;
        bit slot;
        fetch_en       = fe;
        redirect_valid = rv;
        redirect_addr  = 6'(ra);
        instr_ready    = rdy;
        wr_en          = we;
        wr_addr        = 6'(wa);
        wr_data        = wd;
        slot = !m_v || rdy;
        a = -1;
        if (rv) begin
            a    = ra % DEPTH;
            m_pc = (a + 1) % DEPTH;
        end else if (fe && slot) begin
            a    = m_pc;
            m_pc = (m_pc + 1) % DEPTH;
        end else if (rdy) begin
            m_v = 1'b0;
        end
        if (a >= 0) begin
            m_v     = 1'b1;
            m_instr = m_mem[a];
            m_addr  = a;
            m_err   = m_bad[a];
        end
        if (we && wa < DEPTH) begin
            m_mem[wa] = wd;
            m_bad[wa] = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("valid", instr_valid, m_v);
        if (m_v) begin
            chk("instr", instr, m_instr);
            chk("addr", instr_addr, m_addr);
            chk("err", instr_err, m_err);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) apply(1, 0, 0, 1, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = dflt(i);
            m_bad[i] = 1'b0;
        end
        model_reset();
        reset_n        = 1'b0;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        instr_ready    = 1'b0;
        wr_en          = 1'b0;
        wr_addr        = '0;
        wr_data        = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_addr", instr_addr, 0);
        chk("rst_err", instr_err, 0);
        reset_n = 1'b1;

        // First fetch lands one cycle after fetch_en.
        apply(1, 0, 0, 1, 0, 0, 0);
        chk("first_instr", instr, 32'h00A00093);
        chk("first_addr", instr_addr, 0);
        run(63);
        chk("last_addr", instr_addr, 63);
        run(1);
        chk("wrap_addr", instr_addr, 0);
        chk("wrap_instr", instr, 32'h00A00093);

        // Stall at address 4.
        run(4);
        for (int i = 0; i < 5; i++) begin
            apply(1, 0, 0, 0, 0, 0, 0);
            chk("stall_addr", instr_addr, 4);
        end
        run(1);
        chk("release_addr", instr_addr, 5);

        // Redirect discards a held word.
        run(2);
        chk("held7", instr_addr, 7);
        apply(1, 1, 10, 0, 0, 0, 0);
        chk("redir_addr", instr_addr, 10);
        chk("redir_instr", instr, 32'h00108133);
        run(2);
        chk("post_redir", instr_addr, 12);

        // Write colliding with fetch returns the old word.
        run(7);
        apply(1, 0, 0, 1, 1, 20, 32'hDEADBEEF);
        chk("rbw_addr", instr_addr, 20);
        chk("rbw_instr", instr, 32'h00208203);
        apply(1, 1, 20, 1, 0, 0, 0);
        chk("new_word", instr, 32'hDEADBEEF);

        // Corrupt word 3 behind the parity bit.
`ifdef INSTR_MEM_PARITY_EN
        dut.mem[3][0] = ~dut.mem[3][0];
        m_mem[3][0]   = ~m_mem[3][0];
        m_bad[3]      = 1'b1;
`endif
        apply(1, 1, 2, 1, 0, 0, 0);
        chk("err_at2", instr_err, 0);
        run(1);
        chk("err_at3", instr_err, EXP_ERR3);
        run(1);
        chk("err_at4", instr_err, 0);

        // Stop: held until accepted, then idle; restart from idle.
        apply(0, 0, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 0, 0);
        chk("drain_hold", instr_valid, 1);
        apply(0, 0, 0, 1, 0, 0, 0);
        chk("drain_done", instr_valid, 0);
        apply(0, 0, 0, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 0, 0);
        chk("restart", instr_valid, 1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            apply($urandom_range(0, 3) != 0,
                  $urandom_range(0, 7) == 0,
                  int'($urandom_range(0, DEPTH - 1)),
                  $urandom_range(0, 2) != 0,
                  $urandom_range(0, 5) == 0,
                  int'($urandom_range(0, DEPTH - 1)),
                  $urandom);
        end

        // Asynchronous reset mid-stream.
        apply(1, 0, 0, 0, 0, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", instr_valid, 0);
        chk("mid_rst_instr", instr, 0);
        chk("mid_rst_addr", instr_addr, 0);
        chk("mid_rst_err", instr_err, 0);
        model_reset();
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        wr_en          = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("in_rst_valid", instr_valid, 0);
        reset_n = 1'b1;
        apply(1, 0, 0, 1, 0, 0, 0);
        chk("after_rst_addr", instr_addr, 0);
        for (int i = 0; i < 50; i++) begin
            apply($urandom_range(0, 3) != 0, 1'b0, 0,
                  $urandom_range(0, 1) != 0, 1'b0, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
